spi_xfer_ctrl: RTL

- Sequences one 8-bit SPI master transfer around the shift_reg datapath.
- Loads the shift register, drives the slave select and SCLK, and generates the four edge-timing flags that shift_reg uses.
- Issues the receive strobe and the completion pulse.
- Sits between the APB register file (spe/mstr/cpol/cpha/sppr/spr/start) and shift_reg.

---
 rtl/spi_pkg.sv | 31 +++
 rtl/spi_xfer_ctrl_if.sv | 43 ++++
 rtl/spi_baud_gen.sv | 58 +++++
 rtl/spi_xfer_ctrl.sv | 84 ++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transfer controller.
package spi_pkg;

  // Transfer sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } spi_state_e;

  // Eight bits take sixteen SCLK edges.
  localparam int EDGES_PER_BYTE = 16;

  // Smallest half-period the baud generator can run with.
  localparam int MIN_HALF = 2;

  // Width of a half-period value: H can reach 2048.
  localparam int HALF_W = 12;

  // The divisor is D = (sppr+1) * 2^(spr+2), and the half-period is H = D/2.
  // The result therefore ranges from 2 to 2048.
  function automatic logic [HALF_W-1:0] half_period(input logic [2:0] sppr,
                                                    input logic [2:0] spr);
    logic [HALF_W-1:0] h;
    h = ({9'd0, sppr} + 12'd1) << ({1'b0, spr} + 4'd1);
    if (h < HALF_W'(MIN_HALF)) h = HALF_W'(MIN_HALF);
    return h;
  endfunction

endpackage

// File: rtl/spi_xfer_ctrl_if.sv
// Register-file side and shift_reg side signals of the SPI transfer controller.
//
// Handshake: start is a one-cycle request with no ready/back-pressure. The
// controller accepts it only when idle with spe&mstr high; otherwise it is
// dropped. send_data, receive_data and spif are single-cycle strobes.
// tip is a level that stays high from the load cycle to the last SCLK edge.
interface spi_xfer_ctrl_if;
  import spi_pkg::*;

  logic       spe;
  logic       mstr;
  logic       cpol;
  logic       cpha;
  logic [2:0] sppr;
  logic [2:0] spr;
  logic       start;

  logic       send_data;
  logic       ss;
  logic       sclk;
  logic       flag_low;
  logic       flag_high;
  logic       flags_low;
  logic       flags_high;
  logic       receive_data;
  logic       tip;
  logic       spif;
  spi_state_e state_dbg;

  // The controller's side of the interface.
  modport slave (
    input  spe, mstr, cpol, cpha, sppr, spr, start,
    output send_data, ss, sclk, flag_low, flag_high, flags_low, flags_high,
           receive_data, tip, spif, state_dbg
  );

  // The register file's side of the interface.
  modport master (
    output spe, mstr, cpol, cpha, sppr, spr, start,
    input  send_data, ss, sclk, flag_low, flag_high, flags_low, flags_high,
           receive_data, tip, spif, state_dbg
  );
endinterface

// File: rtl/spi_baud_gen.sv
// Half-period counter, SCLK generator and the shift_reg edge-timing flags.
module spi_baud_gen #(
  parameter int HW = 12
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  input  logic          en,
  input  logic          cpol,
  input  logic [HW-1:0] half,
  output logic          sclk_edge,
  output logic          sclk,
  output logic          flag_low,
  output logic          flag_high,
  output logic          flags_low,
  output logic          flags_high
);

  logic [HW-1:0] bc;
  logic          at_last;
  logic          at_prev;

  // Last and second-to-last count of a half-period. Both are gated by en, so
  // SCLK and the flags are quiet whenever the transfer is not running.
  assign at_last   = en && (bc == half - HW'(1));
  assign at_prev   = en && (bc == half - HW'(2));
  assign sclk_edge = at_last;

  // Half-period counter: wraps at H-1 and is held at 0 outside a transfer.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)             bc <= '0;
    else if (!en || at_last)  bc <= '0;
    else                      bc <= bc + HW'(1);
  end

  // SCLK follows cpol when idle and toggles at the end of each half-period.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)      sclk <= 1'b0;
    else if (!en)      sclk <= cpol;
    else if (at_last)  sclk <= ~sclk;
  end

  // Registered edge flags. Each flag appears one cycle after its condition.
  // The flags_* variants lead the flag_* variants by one cycle.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      flag_low   <= 1'b0;
      flag_high  <= 1'b0;
      flags_low  <= 1'b0;
      flags_high <= 1'b0;
    end else begin
      flag_low   <= at_last && !sclk;
      flag_high  <= at_last &&  sclk;
      flags_low  <= at_prev && !sclk;
      flags_high <= at_prev &&  sclk;
    end
  end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Sequences one 8-bit SPI master transfer: load, 16 SCLK edges, done strobe.
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int CNT_W = 10
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  spi_xfer_ctrl_if.slave   bus
);

  // The half-period and its counter carry two bits beyond CNT_W.
  // This lets the largest sppr/spr setting (H=2048) count correctly.
  localparam int HW = CNT_W + 2;

  spi_state_e    state;
  spi_state_e    next_state;
  logic          run_ok;
  logic          baud_en;
  logic          sclk_edge;
  logic [4:0]    ec;
  logic [HW-1:0] h_q;

  // Dropping spe or mstr aborts a transfer in any state.
  assign run_ok  = bus.spe && bus.mstr;
  // Gating with run_ok sends SCLK back to cpol in the same cycle as an abort.
  assign baud_en = (state == XFER) && run_ok;

  spi_baud_gen #(.HW(HW)) u_baud (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .en         (baud_en),
    .cpol       (bus.cpol),
    .half       (h_q),
    .sclk_edge  (sclk_edge),
    .sclk       (bus.sclk),
    .flag_low   (bus.flag_low),
    .flag_high  (bus.flag_high),
    .flags_low  (bus.flags_low),
    .flags_high (bus.flags_high)
  );

  // State register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= next_state;
  end

  // Edge counter and baud setting. Both are sampled at LOAD and held for the
  // whole transfer.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ec  <= '0;
      h_q <= '0;
    end else if (state == LOAD) begin
      ec  <= '0;
      h_q <= HW'(half_period(bus.sppr, bus.spr));
    end else if (sclk_edge) begin
      ec  <= ec + 5'd1;
    end
  end

  // Next-state logic. An abort overrides every other transition.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (bus.start && run_ok) next_state = LOAD;
      LOAD: next_state = XFER;
      XFER: if (sclk_edge && (ec == 5'(EDGES_PER_BYTE - 1))) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (!run_ok) next_state = IDLE;
  end

  // Outputs decoded from the state register. A reset forces them at once.
  assign bus.send_data    = (state == LOAD);
  assign bus.tip          = (state == LOAD) || (state == XFER);
  assign bus.ss           = !bus.tip;
  assign bus.receive_data = (state == DONE);
  assign bus.spif         = (state == DONE);
  assign bus.state_dbg    = state;

endmodule
